fdiv_seq_ctrl: RTL and testbench
================================

# fdiv_seq_ctrl

Sequential controller for the single-precision (IEEE-754 binary32) divider. Accepts an operand pair over a valid/ready handshake, unpacks and screens special cases, sequences a shared one-bit-per-cycle restoring mantissa-division step for 25 iterations, then normalizes and packs the quotient with overflow/underflow/divide-by-zero flags. It sits between the operand source (issue logic) and the result sink, and owns all timing of the divider datapath.

## Interface
- `ITER`, 25, number of quotient bits produced; fixed for binary32 (1 integer bit + 23 fraction bits + 1 normalization bit).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  controller can accept operands (high only in IDLE).
- `a`  in  32  dividend, binary32.
- `b`  in  32  divisor, binary32.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  sink accepts result.
- `result`  out  32  quotient, binary32.
- `overflag`  out  1  exponent overflow; result is signed infinity.
- `underflag`  out  1  exponent underflow; result is signed zero.
- `divzero`  out  1  finite nonzero or zero dividend divided by zero.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, UNPACK, ITER, NORM, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `a` and `b`; go to UNPACK.
- UNPACK:
  - Compute sign = a[31]^b[31] and ext_exp = {2'b0,ea} - {2'b0,eb} + 127 as a 10-bit two's-complement value.
  - Load remainder = {1'b0,1,fa}, which is 25 bits wide.
  - Load divisor = {1,fb}, which is 24 bits wide.
  - Clear the quotient and the iteration counter.
  - Special-case priority, each going directly to DONE:
    1. ea==255 or eb==255 → result 0x7FC00000, no flags.
    2. eb==0 (zero or denormal, flushed) → {sign,8'hFF,23'd0}, `divzero`=1. This includes 0/0.
    3. ea==0 → {sign,31'd0}, no flags.
  - Otherwise go to ITER.
- ITER, once per cycle for counter 0..24:
  - If remainder ≥ divisor: quotient bit (24-counter) = 1 and remainder -= divisor; otherwise the bit is 0.
  - Then remainder <<= 1.
  - After counter==24, go to NORM.
- NORM:
  - If q[24]: frac = q[23:1], exp = ext_exp.
  - Otherwise: frac = q[22:0], exp = ext_exp - 1 (q[23] is guaranteed 1).
  - Rounding is truncation.
  - exp ≥ 255 (signed) → `overflag`=1, result {sign,8'hFF,23'd0}.
  - exp ≤ 0 (signed) → `underflag`=1, result {sign,31'd0}.
  - Otherwise result = {sign,exp[7:0],frac}.
  - Go to DONE.
- DONE: `out_valid`=1. `result` and flags stay stable until `out_ready`; then go to IDLE.
- Flags are mutually exclusive. All three flags are 0 whenever `out_valid`=0.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `result`=0, all flags 0.
  - Internal registers 0.
- Reset mid-operation aborts immediately. The in-flight result is discarded and never presented.
- Normal path: acceptance edge at cycle k; `out_valid` first high in cycle k+28 (1 UNPACK + 25 ITER + 1 NORM + 1 register).
- Special path: `out_valid` high in cycle k+2.
- `in_ready` is combinational from state only. It never depends on `in_valid`.
- `out_ready` in the same cycle `out_valid` rises completes the transfer. IDLE is reached next cycle, so one bubble minimum between operations.
- Throughput: one division per 29 cycles with no backpressure.
- `in_valid` while busy is ignored; the source must hold it.

## Structure
- Package `fdiv_pkg`:
  - State enum.
  - `BIAS`=127, `EXP_MAX`=255, `QNAN`=32'h7FC00000.
  - `ITER`=25.
  - 10-bit signed exponent type.
- Sub-module `fdiv_iter_step`: combinational restoring step. Inputs are the 25-bit remainder and the 24-bit divisor. Outputs are the quotient bit and the next shifted remainder. Instantiated once and reused every ITER cycle.
- FSM, counter, operand/quotient registers and packing stay in `fdiv_seq_ctrl`.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → result 0x40400000, no flags, `out_valid` exactly 28 cycles after acceptance.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated), no flags.
- 0xBF800000 / 0x00000000 → 0xFF800000, `divzero`=1, `out_valid` at k+2. Also 0x7F800000 / 0x3F800000 → 0x7FC00000, no flags.
- 0x7F000000 / 0x3E800000 → 0x7F800000, `overflag`=1.
- 0x00800000 / 0x40000000 → 0x00000000, `underflag`=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles; `result` and flags remain stable and `in_ready`=0 throughout.
  - Assert `rst` at ITER counter 12; all outputs return to reset values within the same cycle.
  - The next operation then yields the correct result.

Source files
------------

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared constants, state encoding and types for the sequential binary32 divider.
package fdiv_pkg;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int ITER    = 25;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ITER   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  typedef logic [2:0] state_t;
  typedef logic signed [9:0] exp_t;
endpackage

// File: rtl/fdiv_iter_step.sv
// fdiv_iter_step: one restoring-division step producing a quotient bit and the shifted remainder.
module fdiv_iter_step (
  input  logic [24:0] rem_i,
  input  logic [23:0] div_i,
  output logic        qbit_o,
  output logic [24:0] rem_o
);
  logic [23:0] diff;
  assign qbit_o = rem_i >= {1'b0, div_i};
  // After a successful subtract the remainder is below the divisor, so 24 bits hold it.
  assign diff   = rem_i[23:0] - div_i;
  assign rem_o  = {qbit_o ? diff : rem_i[23:0], 1'b0};
endmodule

// File: rtl/fdiv_seq_ctrl.sv
// fdiv_seq_ctrl: handshake, special-case screening, 25-step mantissa division and result packing.
module fdiv_seq_ctrl
  import fdiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        overflag_o,
  output logic        underflag_o,
  output logic        divzero_o,
  output logic        busy_o
);
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d;
  exp_t        exp_q, exp_d, exp_n;
  logic [24:0] rem_q, rem_d, quo_q, quo_d, rem_nxt;
  logic [23:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  ea, eb;
  logic [22:0] frac;
  logic        sgn, qbit;

  fdiv_iter_step u_step (.rem_i(rem_q), .div_i(div_q), .qbit_o(qbit), .rem_o(rem_nxt));

  assign ea    = a_q[30:23];
  assign eb    = b_q[30:23];
  assign sgn   = a_q[31] ^ b_q[31];
  assign exp_n = quo_q[24] ? exp_q : exp_q - exp_t'(1);
  assign frac  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    sign_d = sign_q;
    exp_d = exp_q;
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    dz_d = dz_q;
    case (state_q)
      S_IDLE: if (in_valid_i) begin
        a_d = a_i;
        b_d = b_i;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        sign_d = sgn;
        exp_d = exp_t'({2'b0, ea}) - exp_t'({2'b0, eb}) + exp_t'(BIAS);
        rem_d = {2'b01, a_q[22:0]};
        div_d = {1'b1, b_q[22:0]};
        quo_d = '0;
        cnt_d = '0;
        state_d = S_ITER;
        if (ea == 8'hFF || eb == 8'hFF) begin
          res_d = QNAN;
          state_d = S_DONE;
        end else if (eb == 8'h00) begin
          res_d = {sgn, 8'hFF, 23'd0};
          dz_d = 1'b1;
          state_d = S_DONE;
        end else if (ea == 8'h00) begin
          res_d = {sgn, 31'd0};
          state_d = S_DONE;
        end
      end
      // Shifting bits in MSB-first lands the first quotient bit at position 24.
      S_ITER: begin
        quo_d = {quo_q[23:0], qbit};
        rem_d = rem_nxt;
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'(ITER - 1) ? S_NORM : S_ITER;
      end
      S_NORM: begin
        state_d = S_DONE;
        if (exp_n >= exp_t'(EXP_MAX)) begin
          ovf_d = 1'b1;
          res_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_n <= exp_t'(0)) begin
          unf_d = 1'b1;
          res_d = {sign_q, 31'd0};
        end else begin
          res_d = {sign_q, exp_n[7:0], frac};
        end
      end
      S_DONE: if (out_ready_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        dz_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      dz_q <= dz_d;
    end
  end

  assign in_ready_o  = state_q == S_IDLE;
  assign busy_o      = state_q != S_IDLE;
  assign out_valid_o = state_q == S_DONE;
  assign result_o    = res_q;
  assign overflag_o  = ovf_q;
  assign underflag_o = unf_q;
  assign divzero_o   = dz_q;
endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// tb_fdiv_seq_ctrl: directed and random divisions checked against an integer-arithmetic reference.
module tb_fdiv_seq_ctrl;
  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic        overflag, underflag, divzero;
  logic [31:0] a, b, result;
  int          n_chk = 0, n_pass = 0;

  fdiv_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .overflag_o(overflag), .underflag_o(underflag),
    .divzero_o(divzero), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Returns {special, ovf, unf, dz, result}; mantissa quotient from plain integer division.
  function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, e;
    logic   s;
    longint ma, mb, q, fr;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    if (ex == 255 || ey == 255) return {4'b1000, 32'h7FC00000};
    if (ey == 0) return {4'b1001, s, 8'hFF, 23'd0};
    if (ex == 0) return {4'b1000, s, 31'd0};
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    q  = (ma << 24) / mb;
    e  = ex - ey + 127;
    if (q >= (longint'(1) << 24)) fr = (q >> 1) & 64'h7FFFFF;
    else begin
      e  = e - 1;
      fr = q & 64'h7FFFFF;
    end
    if (e >= 255) return {4'b0100, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0010, s, 31'd0};
    return {4'b0000, s, e[7:0], fr[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [35:0] m;
    int lat;
    m = ref_div(x, y);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("latency", lat, m[35] ? 2 : 28);
    check("result", result, m[31:0]);
    check("flags", {overflag, underflag, divzero}, m[34:32]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {in_ready, out_valid, overflag, underflag, divzero, result},
            {2'b01, m[34:32], m[31:0]});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_after", {in_ready, busy, out_valid, overflag, underflag, divzero}, 6'b100000);
  endtask

  function automatic logic [7:0] rnd_exp();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    if (r < 4) return 8'($urandom_range(1, 254));
    return 8'($urandom_range(100, 154));
  endfunction

  initial begin
    logic [31:0] da [7] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
                            32'h7F000000, 32'h00800000, 32'hC0A00000};
    logic [31:0] db [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h3F800000,
                            32'h3E800000, 32'h40000000, 32'h3F000000};
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {in_ready, busy, out_valid, overflag, underflag, divzero, result},
          {6'b100000, 32'd0});
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_op(da[i], db[i], 0);
    run_op(32'h40C00000, 32'h40000000, 10);
    run_op(32'hBF800000, 32'h00000000, 10);
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1 check("reset_mid_iter", {in_ready, busy, out_valid, overflag, underflag, divzero, result},
             {6'b100000, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("no_stale_result", seen, 0);
    run_op(32'h3F800000, 32'h40400000, 0);
    for (int i = 0; i < 40; i++)
      run_op({1'($urandom()), rnd_exp(), 23'($urandom())},
             {1'($urandom()), rnd_exp(), 23'($urandom())}, int'($urandom_range(0, 3)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
